// File: rtl/vend_dispense_ctrl.sv
// Vending dispense controller.
// A purchase request is priced against the saturated credit. A successful sale
// fires a timed product pulse, then timed 5-unit change pulses, and finally a
// one-clock request to clear the upstream credit counter. A cancel in IDLE
// refunds the whole saturated credit as change pulses. All outputs are
// registered, and pulse and gap lengths are measured in tick strobes.
module vend_dispense_ctrl #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 2
) (
  input  logic       MHz,
  input  logic       Reset,
  input  logic       tick,
  input  logic [2:0] credit,
  input  logic       req_a,
  input  logic       req_b,
  input  logic       cancel,
  output logic       busy,
  output logic [1:0] grant,
  output logic       dispense,
  output logic       change5,
  output logic       clr_credit,
  output logic       err
);

  localparam logic [3:0] PULSE_LAST = 4'(PULSE_LEN - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_LEN - 1);
  localparam logic [2:0] PRICE_A    = 3'd3;
  localparam logic [2:0] PRICE_B    = 3'd4;

  typedef enum logic [2:0] {
    IDLE, GRANT, DISP, DGAP, CHG, CGAP, CLEAR
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] chg_q, chg_d;
  // last_b_q = 1 means product B was the most recent successful grant.
  logic       last_b_q, last_b_d;
  logic       busy_q, busy_d;
  logic [1:0] grant_q, grant_d;
  logic       disp_q, disp_d;
  logic       chg5_q, chg5_d;
  logic       clr_q, clr_d;
  logic       err_q, err_d;

  logic [2:0] credit_sat;
  logic       pick_b;
  logic [2:0] price;
  logic       afford;

  // Saturate the credit, arbitrate requests and price the chosen product.
  always_comb begin
    credit_sat = (credit > 3'd4) ? 3'd4 : credit;
    // When both products are requested, serve the one that did not win last.
    pick_b     = req_b & (~req_a | ~last_b_q);
    price      = pick_b ? PRICE_B : PRICE_A;
    afford     = (credit_sat >= price);
  end

  // Next-state and registered-output logic. The grant decision and error flag
  // are resolved when leaving IDLE so that they are visible during GRANT.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    chg_d    = chg_q;
    last_b_d = last_b_q;
    busy_d   = busy_q;
    grant_d  = grant_q;
    disp_d   = disp_q;
    chg5_d   = chg5_q;
    clr_d    = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          state_d = GRANT;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          if (afford) begin
            grant_d  = pick_b ? 2'b10 : 2'b01;
            last_b_d = pick_b;
            chg_d    = credit_sat - price;
          end else begin
            grant_d = 2'b00;
            err_d   = 1'b1;
          end
        end else if (cancel && (credit_sat != 3'd0)) begin
          state_d = CHG;
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          grant_d = 2'b00;
          chg_d   = credit_sat;
          chg5_d  = 1'b1;
        end
      end
      GRANT: begin
        cnt_d = 4'd0;
        if (grant_q == 2'b00) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = DISP;
          disp_d  = 1'b1;
        end
      end
      DISP: begin
        if (tick) begin
          if (cnt_q == PULSE_LAST) begin
            state_d = DGAP;
            cnt_d   = 4'd0;
            disp_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DGAP, CGAP: begin
        if (tick) begin
          if (cnt_q == GAP_LAST) begin
            cnt_d = 4'd0;
            if (chg_q != 3'd0) begin
              state_d = CHG;
              chg5_d  = 1'b1;
            end else begin
              state_d = CLEAR;
              clr_d   = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      CHG: begin
        if (tick) begin
          if (cnt_q == PULSE_LAST) begin
            state_d = CGAP;
            cnt_d   = 4'd0;
            chg5_d  = 1'b0;
            chg_d   = chg_q - 3'd1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      CLEAR: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
        grant_d = 2'b00;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        chg_d   = 3'd0;
        busy_d  = 1'b0;
        grant_d = 2'b00;
        disp_d  = 1'b0;
        chg5_d  = 1'b0;
      end
    endcase
  end

  // State register; reset aborts any sequence immediately and silently.
  always_ff @(posedge MHz or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      chg_q    <= 3'd0;
      last_b_q <= 1'b1;
      busy_q   <= 1'b0;
      grant_q  <= 2'b00;
      disp_q   <= 1'b0;
      chg5_q   <= 1'b0;
      clr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      chg_q    <= chg_d;
      last_b_q <= last_b_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
      disp_q   <= disp_d;
      chg5_q   <= chg5_d;
      clr_q    <= clr_d;
      err_q    <= err_d;
    end
  end

  assign busy       = busy_q;
  assign grant      = grant_q;
  assign dispense   = disp_q;
  assign change5    = chg5_q;
  assign clr_credit = clr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed testbench for vend_dispense_ctrl with PULSE_LEN=4 and GAP_LEN=2.
// Outputs are sampled on the falling clock edge as the packed vector
// {busy, grant[1:0], dispense, change5, clr_credit, err}.
module tb_vend_dispense_ctrl;

  logic       MHz = 1'b0;
  logic       Reset;
  logic       tick;
  logic [2:0] credit;
  logic       req_a;
  logic       req_b;
  logic       cancel;
  logic       busy;
  logic [1:0] grant;
  logic       dispense;
  logic       change5;
  logic       clr_credit;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] obs;

  localparam logic [6:0] IDLE_V = 7'b0_00_0000;

  always #5 MHz = ~MHz;

  vend_dispense_ctrl #(.PULSE_LEN(4), .GAP_LEN(2)) dut (
    .MHz       (MHz),
    .Reset     (Reset),
    .tick      (tick),
    .credit    (credit),
    .req_a     (req_a),
    .req_b     (req_b),
    .cancel    (cancel),
    .busy      (busy),
    .grant     (grant),
    .dispense  (dispense),
    .change5   (change5),
    .clr_credit(clr_credit),
    .err       (err)
  );

  function automatic logic [6:0] pack_out();
    return {busy, grant, dispense, change5, clr_credit, err};
  endfunction

  function automatic void add(input logic [6:0] v, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(v);
  endfunction

  // Expected trace of one successful sale, from GRANT through the first IDLE cycle.
  function automatic void add_purchase(input logic [1:0] g, input int n_change);
    add({1'b1, g, 4'b0000}, 1);
    add({1'b1, g, 4'b1000}, 4);
    add({1'b1, g, 4'b0000}, 2);
    for (int c = 0; c < n_change; c++) begin
      add({1'b1, g, 4'b0100}, 4);
      add({1'b1, g, 4'b0000}, 2);
    end
    add({1'b1, g, 4'b0010}, 1);
    add(IDLE_V, 1);
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(negedge MHz);
    obs = pack_out();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_hold got %b want %b", obs, IDLE_V);
    end
    Reset = 1'b0;
    @(negedge MHz);
    obs = pack_out();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL reset_release got %b want %b", obs, IDLE_V);
    end
  endtask

  // Single request (optionally with a coincident cancel), followed through to IDLE.
  task automatic test_purchase(input string name, input logic [2:0] cr, input logic a,
                               input logic b, input logic c, input logic [1:0] g,
                               input int n_change);
    exp_q.delete();
    add_purchase(g, n_change);
    add(IDLE_V, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      credit = cr;
      req_a  = (i == 0) ? a : 1'b0;
      req_b  = (i == 0) ? b : 1'b0;
      cancel = (i == 0) ? c : 1'b0;
      @(negedge MHz);
      obs = pack_out();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle %0d got %b want %b", name, i, obs, exp_q[i]);
      end
    end
  endtask

  task automatic test_insufficient();
    exp_q.delete();
    add(7'b1_00_0001, 1);
    add(IDLE_V, 4);
    for (int i = 0; i < exp_q.size(); i++) begin
      credit = 3'd2;
      req_b  = (i == 0);
      @(negedge MHz);
      obs = pack_out();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL insufficient cycle %0d got %b want %b", i, obs, exp_q[i]);
      end
    end
    req_b = 1'b0;
  endtask

  task automatic test_round_robin();
    Reset = 1'b1;
    @(negedge MHz);
    Reset = 1'b0;
    exp_q.delete();
    add_purchase(2'b01, 1);
    add_purchase(2'b10, 0);
    add_purchase(2'b01, 1);
    for (int i = 0; i < exp_q.size(); i++) begin
      credit = 3'd4;
      req_a  = (i <= 24);
      req_b  = (i <= 24);
      @(negedge MHz);
      obs = pack_out();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL round_robin cycle %0d got %b want %b", i, obs, exp_q[i]);
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  // Refund of credit 3; tick every m-th cycle, aligned so the entry edge is a tick edge.
  task automatic test_cancel(input int m);
    exp_q.delete();
    for (int k = 0; k < 3; k++) begin
      add(7'b1_00_0100, 4 * m);
      add(7'b1_00_0000, 2 * m);
    end
    add(7'b1_00_0010, 1);
    add(IDLE_V, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      credit = 3'd3;
      cancel = (i == 0);
      tick   = ((i % m) == 0);
      @(negedge MHz);
      obs = pack_out();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL cancel_x%0d cycle %0d got %b want %b", m, i, obs, exp_q[i]);
      end
    end
    cancel = 1'b0;
    tick   = 1'b1;
  endtask

  task automatic test_cancel_zero();
    for (int i = 0; i < 4; i++) begin
      credit = 3'd0;
      cancel = (i < 3);
      @(negedge MHz);
      obs = pack_out();
      checks++;
      if (obs !== IDLE_V) begin
        errors++;
        $display("FAIL cancel_zero cycle %0d got %b want %b", i, obs, IDLE_V);
      end
    end
    cancel = 1'b0;
  endtask

  task automatic test_reset_mid_dispense();
    exp_q.delete();
    add(7'b1_01_0000, 1);
    add(7'b1_01_1000, 2);
    for (int i = 0; i < exp_q.size(); i++) begin
      credit = 3'd3;
      req_a  = (i == 0);
      @(negedge MHz);
      obs = pack_out();
      checks++;
      if (obs !== exp_q[i]) begin
        errors++;
        $display("FAIL mid_reset_pre cycle %0d got %b want %b", i, obs, exp_q[i]);
      end
    end
    req_a = 1'b0;
    // Second dispense cycle: assert reset between clock edges.
    Reset = 1'b1;
    #1;
    obs = pack_out();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL mid_reset_async got %b want %b", obs, IDLE_V);
    end
    @(negedge MHz);
    obs = pack_out();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL mid_reset_held got %b want %b", obs, IDLE_V);
    end
    Reset = 1'b0;
    @(negedge MHz);
    obs = pack_out();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL mid_reset_after got %b want %b", obs, IDLE_V);
    end
    credit = 3'd4;
    req_a  = 1'b1;
    req_b  = 1'b1;
    @(negedge MHz);
    req_a  = 1'b0;
    req_b  = 1'b0;
    obs = pack_out();
    checks++;
    if (obs !== 7'b1_01_0000) begin
      errors++;
      $display("FAIL mid_reset_regrant got %b want %b", obs, 7'b1_01_0000);
    end
    repeat (16) @(negedge MHz);
    obs = pack_out();
    checks++;
    if (obs !== IDLE_V) begin
      errors++;
      $display("FAIL mid_reset_final got %b want %b", obs, IDLE_V);
    end
  endtask

  initial begin
    Reset  = 1'b1;
    tick   = 1'b1;
    credit = 3'd0;
    req_a  = 1'b0;
    req_b  = 1'b0;
    cancel = 1'b0;
    test_reset();
    test_purchase("exact_a", 3'd3, 1'b1, 1'b0, 1'b0, 2'b01, 0);
    test_purchase("change_a", 3'd4, 1'b1, 1'b0, 1'b0, 2'b01, 1);
    test_insufficient();
    test_purchase("sat_b", 3'd7, 1'b0, 1'b1, 1'b0, 2'b10, 0);
    test_purchase("sat_a", 3'd6, 1'b1, 1'b0, 1'b0, 2'b01, 1);
    test_purchase("req_over_cancel", 3'd3, 1'b1, 1'b0, 1'b1, 2'b01, 0);
    test_round_robin();
    test_cancel(1);
    test_cancel(3);
    test_cancel_zero();
    test_reset_mid_dispense();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
